// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared op codes, state encoding and width for muldiv_hilo.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
//  Module      : muldiv_step
//  Description : One shift-add multiply or restoring shift-subtract divide step.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_mul,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        hi_next = '0;
        lo_next = '0;
        if (is_mul) begin
            // multiplier bits are consumed from lo while product bits shift in on top
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_next = diff[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_next = shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_hilo.sv
// ============================================================================
//  Module      : muldiv_hilo
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_hilo
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iRs,
    input  logic [WIDTH-1:0] iRt,
    input  logic             iAbort,
    output logic             oBusy,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo
);

    md_state_t          state, next_state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               op_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_signed = (iOp == MD_MULT) || (iOp == MD_DIV);
        rs_neg    = op_signed & iRs[WIDTH-1];
        rt_neg    = op_signed & iRt[WIDTH-1];
        rs_mag    = rs_neg ? (~iRs + WIDTH'(1)) : iRs;
        rt_mag    = rt_neg ? (~iRt + WIDTH'(1)) : iRt;
        prod_fix  = neg_q ? (~{acc_hi, acc_lo} + (2*WIDTH)'(1)) : {acc_hi, acc_lo};
        quo_fix   = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_fix   = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_mul  (~is_div),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .opnd    (opnd),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    always_comb begin
        next_state = state;
        case (state)
            MD_IDLE: if (iStart && (iOp <= MD_DIVU)) next_state = MD_CALC;
            MD_CALC: begin
                if (iAbort)                            next_state = MD_IDLE;
                else if (count == CNT_W'(WIDTH - 1))   next_state = MD_FIX;
            end
            MD_FIX:  next_state = MD_IDLE;
            default: next_state = MD_IDLE;
        endcase
    end

    assign oBusy = (state != MD_IDLE);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= MD_IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            oHi      <= '0;
            oLo      <= '0;
        end else begin
            state <= next_state;
            case (state)
                MD_IDLE: if (iStart) begin
                    case (iOp)
                        MD_MTHI: oHi <= iRs;
                        MD_MTLO: oLo <= iRs;
                        MD_MULT, MD_MULTU: begin
                            is_div <= 1'b0;
                            acc_hi <= '0;
                            acc_lo <= rt_mag;
                            opnd   <= rs_mag;
                            neg_q  <= rs_neg ^ rt_neg;
                            count  <= '0;
                        end
                        MD_DIV, MD_DIVU: begin
                            is_div   <= 1'b1;
                            acc_hi   <= '0;
                            acc_lo   <= rs_mag;
                            opnd     <= rt_mag;
                            neg_q    <= rs_neg ^ rt_neg;
                            neg_r    <= rs_neg;
                            div_zero <= (iRt == '0);
                            count    <= '0;
                        end
                        default: ;
                    endcase
                end
                MD_CALC: if (!iAbort) begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + CNT_W'(1);
                end
                MD_FIX: if (!iAbort) begin
                    if (!is_div) begin
                        oHi <= prod_fix[2*WIDTH-1:WIDTH];
                        oLo <= prod_fix[WIDTH-1:0];
                    end else begin
                        // a zero divisor leaves |rs| as remainder, so HI comes back as rs
                        oHi <= rem_fix;
                        oLo <= div_zero ? '1 : quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
// ============================================================================
//  Module      : tb_muldiv_hilo
//  Description : Directed self-checking bench for muldiv_hilo.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    int cyc;

    muldiv_hilo dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iStart (start),
        .iOp    (op),
        .iRs    (rs),
        .iRt    (rt),
        .iAbort (abort),
        .oBusy  (busy),
        .oHi    (hi),
        .oLo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues an op at one edge and counts negedge samples with busy high (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        check("multu_max_cycles", cyc, 32'd33);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);

        run_op(3'd0, 32'hFFFFFFFD, 32'd7, cyc);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFEB);

        run_op(3'd0, 32'h80000000, 32'h80000000, cyc);
        check("mult_minmin_hi", hi, 32'h40000000);
        check("mult_minmin_lo", lo, 32'h00000000);

        run_op(3'd0, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("mult_min_m1_hi", hi, 32'h00000000);
        check("mult_min_m1_lo", lo, 32'h80000000);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        run_op(3'd3, 32'd1000, 32'd7, cyc);
        check("divu_lo", lo, 32'd142);
        check("divu_hi", hi, 32'd6);

        run_op(3'd3, 32'd100, 32'd0, cyc);
        check("divu_zero_cycles", cyc, 32'd33);
        check("divu_zero_hi", hi, 32'd100);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);

        run_op(3'd2, 32'hFFFFFFFB, 32'd0, cyc);
        check("div_zero_hi", hi, 32'hFFFFFFFB);
        check("div_zero_lo", lo, 32'hFFFFFFFF);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd5; rs = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi_kept", hi, 32'h12345678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // MULTU 5*6, stray MTHI while busy, abort at cycle 10
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs = 32'd5; rt = 32'd6;
        @(negedge clk);
        op = 3'd4; rs = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'h12345678);
        check("abort_lo", lo, 32'h9ABCDEF0);
        repeat (40) @(negedge clk);
        check("abort_hi_late", hi, 32'h12345678);

        run_op(3'd1, 32'd5, 32'd6, cyc);
        check("multu_small_hi", hi, 32'd0);
        check("multu_small_lo", lo, 32'd30);

        // reset dropped mid-calculation, checked before any clock edge
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs = 32'hCAFEF00D;
        @(negedge clk);
        op = 3'd1; rs = 32'd5; rt = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_hi", hi, 32'hCAFEF00D);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd30 & 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
